rtc_hms_counter: RTL
====================

Name: rtc_hms_counter

Overview:
- Parametrised time-of-day counter: hours, minutes and seconds in packed BCD, advanced by an internal prescaler from the system clock.
- Generalises the single-digit BCD and mod-6 cascades into a full HH:MM:SS chain.
- Adds synchronous time load with validity check, runtime 12/24-hour display mode, a per-second tick and an end-of-day carry.
- Feeds the display/driver layer and any alarm or timer logic.

Parameters:
- TICK_DIV, 10, clk cycles per one-second tick (10 at a 100 ms clock); legal range 1..2**DIV_W.
- DIV_W, 4, prescaler register width.

Ports:
- clk  input  1  clock; all state updates on posedge.
- clr_  input  1  asynchronous active-low reset.
- enb  input  1  count enable; low freezes prescaler and time.
- load  input  1  synchronous load strobe, one cycle.
- set_hh  input  8  load hours, packed BCD, always 24-hour (0x00..0x23).
- set_mm  input  8  load minutes, packed BCD (0x00..0x59).
- set_ss  input  8  load seconds, packed BCD (0x00..0x59).
- mode12  input  1  display mode: 0 = 24-hour, 1 = 12-hour.
- sec  output  8  seconds, packed BCD.
- min  output  8  minutes, packed BCD.
- hour  output  8  displayed hours, packed BCD, per mode12.
- pm  output  1  PM flag; 12-hour mode only, else 0.
- tick  output  1  one-cycle pulse on each seconds advance.
- tc  output  1  end-of-day pulse, asserted with the tick that wraps 23:59:59 to 00:00:00.
- load_err  output  1  registered one-cycle pulse on a rejected load.

Behaviour:
- Reset (clr_ low, asynchronous, dominates everything):
  - prescaler = 0; internal sec/min/hour24 = 0x00; load_err = 0.
  - Outputs: hour = 0x00, pm = 0 in 24-hour mode; hour = 0x12, pm = 0 in 12-hour mode.
  - tick = 0 and tc = 0 while reset is held.
- Prescaler:
  - When enb=1 and load=0, counts 0..TICK_DIV-1 and wraps to 0.
  - tick = enb & ~load & (prescaler == TICK_DIV-1). tick is combinational; the time advances on the same edge.
  - TICK_DIV=1: tick is high every enabled cycle.
- Time chain (on tick):
  - Seconds: units digit 0..9 with carry into tens 0..5; 0x59 -> 0x00 and carries into minutes.
  - Minutes: identical to seconds; carries into hours.
  - Hours (24-hour internally): 0x09 -> 0x10, 0x19 -> 0x20, 0x23 -> 0x00.
  - tc = tick & (time == 23:59:59).
- Display conversion (combinational from hour24):
  - 24-hour mode: hour = hour24, pm = 0.
  - 12-hour mode: 00 -> 12 AM; 01..11 -> same value AM; 12 -> 12 PM; 13..23 -> hour24 minus 12, BCD-corrected, PM.
  - Toggling mode12 never alters stored time.
- Load:
  - Legal load:
    - Every digit is <= 9.
    - set_mm and set_ss tens digits are <= 5.
    - set_hh is <= 0x23.
  - Legal load effect: time <= set values; prescaler <= 0.
  - Load has priority over a coincident tick; that second is dropped, not applied after the load.
  - Illegal load: time and prescaler unchanged; load_err = 1 for the next cycle.
  - Load works regardless of enb.
- enb low: prescaler and time hold; tick = 0 and tc = 0.
- Reset released mid-second: counting restarts with a full TICK_DIV period.

Optional Feature:
- Macro: RTC_ALARM_EN.
- Defined:
  - Adds inputs alarm_hh [8] (24-hour BCD), alarm_mm [8] and alarm_on [1].
  - Adds output alarm [1].
  - alarm is a sticky register, set on the edge where counting (not load) makes the time alarm_hh:alarm_mm:00 while alarm_on=1.
  - alarm is cleared when alarm_on=0 (synchronous) or by clr_.
- Undefined: those ports and all alarm logic are absent; nothing else changes.

Test Plan:
- Pulse clr_ low mid-count at 00:00:07 -> all time outputs 0x00, tick=0, load_err=0 immediately, independent of clk.
- TICK_DIV=10, enb=1 for 600 clk from reset -> exactly 60 tick pulses, time 00:01:00; with enb=0 for 50 clk inserted -> still 00:00:55 at clk 600.
- Load 23:59:58, run 20 clk -> 00:00:00; tc high exactly one cycle, coincident with the 23:59:59 -> 00:00:00 tick.
- mode12=1 with loads 00:00:00, 12:30:00, 13:05:00 and 23:59:59:
  - 00:00:00 -> hour 0x12, pm 0.
  - 12:30:00 -> hour 0x12, pm 1.
  - 13:05:00 -> hour 0x01, pm 1.
  - 23:59:59 -> hour 0x11, pm 1.
- Illegal loads:
  - set_hh=0x24 -> load_err one cycle, time unchanged.
  - set_ss=0x5A -> load_err one cycle, time unchanged.
  - set_mm=0x60 -> load_err one cycle, time unchanged.
  - load coincident with tick -> loaded value exact, prescaler 0.
- RTC_ALARM_EN: alarm_hh=0x00, alarm_mm=0x01, alarm_on=1, run from reset -> alarm rises at the 00:01:00 edge and stays high; drop alarm_on -> alarm 0 next cycle.

Source files
------------

// File: rtl/rtc_hms_counter_if.sv
// rtc_hms_counter_if: control, load and time-display signals of the HH:MM:SS counter.
// The master modport drives the controls (enable, load, mode); the slave modport is the counter itself.
// Optional build macro RTC_ALARM_EN adds the alarm inputs and the sticky alarm output.
interface rtc_hms_counter_if;
    logic       enb;
    logic       load;
    logic [7:0] set_hh;
    logic [7:0] set_mm;
    logic [7:0] set_ss;
    logic       mode12;
    logic [7:0] sec;
    logic [7:0] min;
    logic [7:0] hour;
    logic       pm;
    logic       tick;
    logic       tc;
    logic       load_err;
`ifdef RTC_ALARM_EN
    logic [7:0] alarm_hh;
    logic [7:0] alarm_mm;
    logic       alarm_on;
    logic       alarm;

    modport master (
        output enb, load, set_hh, set_mm, set_ss, mode12,
        output alarm_hh, alarm_mm, alarm_on,
        input  sec, min, hour, pm, tick, tc, load_err, alarm
    );

    modport slave (
        input  enb, load, set_hh, set_mm, set_ss, mode12,
        input  alarm_hh, alarm_mm, alarm_on,
        output sec, min, hour, pm, tick, tc, load_err, alarm
    );
`else
    modport master (
        output enb, load, set_hh, set_mm, set_ss, mode12,
        input  sec, min, hour, pm, tick, tc, load_err
    );

    modport slave (
        input  enb, load, set_hh, set_mm, set_ss, mode12,
        output sec, min, hour, pm, tick, tc, load_err
    );
`endif
endinterface

// File: rtl/rtc_hms_counter.sv
// rtc_hms_counter: packed-BCD time-of-day counter (HH:MM:SS, 24-hour internally).
// A prescaler divides clk by TICK_DIV to produce the one-second tick. Time can be loaded
// synchronously with a legality check; the hours are shown in 12- or 24-hour form at runtime.
// Optional build macro RTC_ALARM_EN adds a sticky alarm that fires on HH:MM:00 reached by counting.
module rtc_hms_counter #(
    parameter int TICK_DIV = 10,
    parameter int DIV_W    = 4
) (
    input  logic                clk,
    input  logic                clr_,
    rtc_hms_counter_if.slave    bus
);

    logic [DIV_W-1:0] r_presc;
    logic [7:0]       r_sec;
    logic [7:0]       r_min;
    logic [7:0]       r_hour;
    logic             r_loadErr;

    logic             w_lastCount;
    logic             w_tick;
    logic             w_loadOk;
    logic             w_secWrap;
    logic             w_minWrap;
    logic             w_endOfDay;
    logic [7:0]       w_secNext;
    logic [7:0]       w_minNext;
    logic [7:0]       w_hourNext;
    logic [4:0]       w_hourBin;
    logic [4:0]       w_hour12;
    logic [7:0]       w_hourDisp;
    logic             w_pm;

    // One BCD step of a 00..59 field; wraps 0x59 back to 0x00.
    function automatic logic [7:0] incMod60(input logic [7:0] v);
        logic [7:0] res;
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5) begin
                res = 8'h00;
            end else begin
                res = {v[7:4] + 4'd1, 4'd0};
            end
        end else begin
            res = {v[7:4], v[3:0] + 4'd1};
        end
        return res;
    endfunction

    // One BCD step of the 00..23 hour field; wraps 0x23 back to 0x00.
    function automatic logic [7:0] incHour(input logic [7:0] v);
        logic [7:0] res;
        if (v == 8'h23) begin
            res = 8'h00;
        end else if (v[3:0] == 4'd9) begin
            res = {v[7:4] + 4'd1, 4'd0};
        end else begin
            res = {v[7:4], v[3:0] + 4'd1};
        end
        return res;
    endfunction

    // A packed-BCD byte whose digits are both decimal and whose tens digit is at most maxTens.
    function automatic logic bcdOk(input logic [7:0] v, input logic [3:0] maxTens);
        return (v[3:0] <= 4'd9) && (v[7:4] <= maxTens);
    endfunction

    assign w_lastCount = (r_presc == DIV_W'(TICK_DIV - 1));

    // The tick is forced low while reset is held so a TICK_DIV of 1 cannot leak a pulse.
    assign w_tick = clr_ & bus.enb & ~bus.load & w_lastCount;

    assign w_loadOk = bcdOk(bus.set_ss, 4'd5) &&
                      bcdOk(bus.set_mm, 4'd5) &&
                      bcdOk(bus.set_hh, 4'd2) &&
                      (bus.set_hh <= 8'h23);

    assign w_secWrap  = (r_sec == 8'h59);
    assign w_minWrap  = (r_min == 8'h59);
    assign w_endOfDay = w_secWrap & w_minWrap & (r_hour == 8'h23);

    assign w_secNext  = incMod60(r_sec);
    assign w_minNext  = w_secWrap ? incMod60(r_min) : r_min;
    assign w_hourNext = (w_secWrap & w_minWrap) ? incHour(r_hour) : r_hour;

    assign w_hourBin = (5'(r_hour[7:4]) * 5'd10) + 5'(r_hour[3:0]);

    // Prescaler: a legal load restarts the second; otherwise it counts while enabled and wraps on the tick.
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            r_presc <= '0;
        end else if (bus.load) begin
            if (w_loadOk) begin
                r_presc <= '0;
            end
        end else if (bus.enb) begin
            if (w_lastCount) begin
                r_presc <= '0;
            end else begin
                r_presc <= r_presc + DIV_W'(1);
            end
        end
    end

    // Time registers: a legal load wins over a coincident tick, which is then simply dropped.
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            r_sec  <= 8'h00;
            r_min  <= 8'h00;
            r_hour <= 8'h00;
        end else if (bus.load) begin
            if (w_loadOk) begin
                r_sec  <= bus.set_ss;
                r_min  <= bus.set_mm;
                r_hour <= bus.set_hh;
            end
        end else if (w_tick) begin
            r_sec  <= w_secNext;
            r_min  <= w_minNext;
            r_hour <= w_hourNext;
        end
    end

    // Rejected-load flag: high for exactly the cycle after an illegal load strobe.
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            r_loadErr <= 1'b0;
        end else begin
            r_loadErr <= bus.load & ~w_loadOk;
        end
    end

    // Display conversion from the stored 24-hour value; the stored time is never touched.
    always_comb begin
        w_hourDisp = r_hour;
        w_pm       = 1'b0;
        w_hour12   = 5'd0;
        if (bus.mode12) begin
            if (w_hourBin == 5'd0) begin
                w_hourDisp = 8'h12;
            end else if (w_hourBin < 5'd12) begin
                w_hourDisp = r_hour;
            end else begin
                w_pm     = 1'b1;
                w_hour12 = (w_hourBin == 5'd12) ? 5'd12 : (w_hourBin - 5'd12);
                if (w_hour12 >= 5'd10) begin
                    w_hourDisp = {4'd1, 4'(w_hour12 - 5'd10)};
                end else begin
                    w_hourDisp = {4'd0, 4'(w_hour12)};
                end
            end
        end
    end

`ifdef RTC_ALARM_EN
    logic r_alarm;
    logic w_alarmHit;

    assign w_alarmHit = w_tick &&
                        (w_hourNext == bus.alarm_hh) &&
                        (w_minNext == bus.alarm_mm) &&
                        (w_secNext == 8'h00);

    // Sticky alarm: set only when counting reaches HH:MM:00, cleared whenever the alarm is switched off.
    always_ff @(posedge clk or negedge clr_) begin
        if (!clr_) begin
            r_alarm <= 1'b0;
        end else if (!bus.alarm_on) begin
            r_alarm <= 1'b0;
        end else if (w_alarmHit) begin
            r_alarm <= 1'b1;
        end
    end

    assign bus.alarm = r_alarm;
`endif

    assign bus.sec      = r_sec;
    assign bus.min      = r_min;
    assign bus.hour     = w_hourDisp;
    assign bus.pm       = w_pm;
    assign bus.tick     = w_tick;
    assign bus.tc       = w_tick & w_endOfDay;
    assign bus.load_err = r_loadErr;

endmodule
